axis_fir_interp: RTL and testbench
==================================

AXIS_FIR_INTERP -- requirements
Module: axis_fir_interp

Interface
REQ-001 SHALL have parameter coeff, type fir_pkg::fir_coeff_t, default fir_pkg::FIR_COEFF_DEFAULT, signed prototype low-pass taps h[0..N-1].
REQ-002 SHALL have parameter INTERP_FACTOR, type int, default fir_pkg::INTERP_FACTOR_DEFAULT (4), outputs per input sample L.
REQ-003 ACLK  input  1  sole clock, taken from s_axis.ACLK; m_axis.ACLK is the same net.
REQ-004 ARESETn  input  1  asynchronous, active-low reset, taken from s_axis.ARESETn.
REQ-005 s_axis  axis_if.rx  AXIS_PARAMETERS (TDATA 64)  input samples: TVALID, TREADY, TDATA, TLAST.
REQ-006 m_axis  axis_if.tx  AXIS_PARAMETERS (TDATA 64)  interpolated samples: TVALID, TREADY, TDATA, TLAST.
REQ-007 SHALL raise an elaboration $error if s_axis/m_axis AXIS_PARAMETERS differ, L < 2, or $size(coeff) is not a multiple of L.

Function
REQ-008 SHALL implement a polyphase interpolator: P = N/L taps per phase; output for phase k of input n is the sum over j=0..P-1 of h[j*L+k]*x[n-j].
REQ-009 SHALL hold a P-entry signed 64-bit history register, shifted only on an accepted input (s_axis.TVALID && s_axis.TREADY).
REQ-010 SHALL use a two-state FSM: IDLE (no burst pending) and EMIT (phase counter 0..L-1 valid).
REQ-011 IDLE: s_axis.TREADY=1, m_axis.TVALID=0; on accept -> shift history, phase=0, EMIT.
REQ-012 EMIT: m_axis.TVALID=1; TDATA = phase-k dot product of current history; TDATA/TLAST SHALL remain stable while TVALID && !TREADY.
REQ-013 EMIT, output handshake, phase<L-1: phase increments, stay EMIT.
REQ-014 EMIT, output handshake, phase=L-1, s_axis.TVALID=1: accept the new sample in the same cycle, phase=0, stay EMIT (no bubble).
REQ-015 EMIT, output handshake, phase=L-1, s_axis.TVALID=0: go IDLE.
REQ-016 s_axis.TREADY SHALL be 1 in IDLE, or in EMIT only when phase=L-1 && m_axis.TREADY=1; 0 otherwise.
REQ-017 Latency: first output of a burst valid the cycle after input acceptance; sustained throughput one output per cycle, one input per L cycles.
REQ-018 Input TLAST SHALL be captured on accept and driven on m_axis.TLAST for phase L-1 only; 0 on other phases.
REQ-019 Arithmetic: each coefficient sign-extended to 64 bits, product truncated to 64 bits, accumulation wraps modulo 2^64; no saturation.
REQ-020 No warm-up gating: zero history before the first inputs; every burst, including the first, is emitted.

Reset
REQ-021 ARESETn low SHALL immediately force: state IDLE, phase 0, history all 0, stored TLAST 0, m_axis.TVALID 0, m_axis.TLAST 0, s_axis.TREADY 0.
REQ-022 Reset mid-burst SHALL abandon remaining phases without emitting them; first cycle after deassertion s_axis.TREADY=1.

Structure
REQ-023 fir_pkg SHALL gain INTERP_FACTOR_DEFAULT and the enum interp_state_t {IDLE, EMIT}; fir_coeff_t is reused unchanged.
REQ-024 SHALL instantiate one sub-module fir_phase_mac (combinational P-tap dot product of history and phase-selected coefficients); FSM, counter, history and TLAST live in axis_fir_interp.
REQ-025 SHALL not instantiate axis_skid_buffer; handshake timing per REQ-011..016.

Verification (coeff = {1,2,3,4,5,6,7,8}, L=4, P=2)
REQ-026 Impulse: inputs 1,0, m ready always -> outputs 1,2,3,4,5,6,7,8; TVALID asserted from the cycle after the first accept.
REQ-027 Two-sample: inputs 10,20 -> 10,20,30,40 then 70,100,130,160.
REQ-028 Backpressure: m_axis.TREADY low 3 cycles at phase 1 of impulse -> TDATA held at 2, TVALID held, s_axis.TREADY 0 throughout.
REQ-029 Continuous stream: s_axis.TVALID always 1, TLAST on 2nd input -> outputs every cycle with no gap, s_axis.TREADY pulses once per 4 cycles, m_axis.TLAST only on 8th output.
REQ-030 Reset mid-burst: ARESETn low during phase 1 of impulse -> TVALID 0 same cycle; after release, input 1 -> 1,2,3,4 (history cleared).
REQ-031 Wrap: coeff all 2, input 0x7FFF_FFFF_FFFF_FFFF after reset -> each first-burst output 0xFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the polyphase FIR interpolator.
//   fir_coeff_t            : prototype low-pass tap set h[0..FIR_N-1], signed
//   FIR_COEFF_DEFAULT      : default tap set {1,2,...,8}
//   INTERP_FACTOR_DEFAULT  : default outputs per input sample (L)
//   interp_state_t         : interpolator control states
//   coeff_sext()           : sign-extends one tap to the 64-bit datapath
package fir_pkg;

  localparam int FIR_N       = 8;
  localparam int COEFF_W     = 16;
  localparam int AXIS_DATA_W = 64;

  typedef logic signed [COEFF_W-1:0] fir_coeff_t [FIR_N];

  localparam fir_coeff_t FIR_COEFF_DEFAULT = '{16'sd1, 16'sd2, 16'sd3, 16'sd4,
                                               16'sd5, 16'sd6, 16'sd7, 16'sd8};

  localparam int INTERP_FACTOR_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } interp_state_t;

  function automatic logic signed [63:0] coeff_sext(input logic signed [COEFF_W-1:0] c);
    return {{(64 - COEFF_W){c[COEFF_W-1]}}, c};
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream bundle carrying clock, reset, TVALID/TREADY/TDATA/TLAST.
//   ACLK, ARESETn : clock and active-low asynchronous reset
//   rx modport    : sink side (drives TREADY)
//   tx modport    : source side (drives TVALID, TDATA, TLAST)
interface axis_if #(
  parameter int TDATA_W = 64
) (
  input logic ACLK,
  input logic ARESETn
);
  logic               TVALID;
  logic               TREADY;
  logic [TDATA_W-1:0] TDATA;
  logic               TLAST;

  modport rx (input ACLK, input ARESETn, input TVALID, input TDATA, input TLAST,
              output TREADY);
  modport tx (input ACLK, input ARESETn, input TREADY,
              output TVALID, output TDATA, output TLAST);
endinterface

// File: rtl/fir_phase_mac.sv
// Combinational P-tap dot product for one polyphase branch.
//   i_phase : phase k selecting taps h[j*L+k]
//   i_hist  : sample history, i_hist[j] = x[n-j]
//   o_acc   : sum over j of h[j*L+k]*x[n-j], wrapping modulo 2^64
module fir_phase_mac
  import fir_pkg::*;
#(
  parameter fir_coeff_t COEFF = FIR_COEFF_DEFAULT,
  parameter int         L     = INTERP_FACTOR_DEFAULT,
  parameter int         P     = FIR_N / INTERP_FACTOR_DEFAULT,
  parameter int         PH_W  = 2
) (
  input  logic        [PH_W-1:0] i_phase,
  input  logic signed [63:0]     i_hist [P],
  output logic signed [63:0]     o_acc
);

  // Multiply-accumulate across the branch; products and sum keep only 64 bits.
  always_comb begin
    o_acc = 64'sd0;
    for (int j = 0; j < P; j++) begin
      o_acc = o_acc + coeff_sext(COEFF[j * L + int'(i_phase)]) * i_hist[j];
    end
  end

endmodule

// File: rtl/axis_fir_interp.sv
// AXI4-Stream polyphase FIR interpolator: each accepted input sample produces
// INTERP_FACTOR output samples, one per phase, back-to-back when the sink is ready.
//   coeff         : prototype taps h[0..N-1]
//   INTERP_FACTOR : L, outputs per input
//   s_axis        : input samples (clock and reset are taken from this bundle)
//   m_axis        : interpolated samples, TLAST only on the last phase
module axis_fir_interp
  import fir_pkg::*;
#(
  parameter fir_coeff_t coeff         = FIR_COEFF_DEFAULT,
  parameter int         INTERP_FACTOR = INTERP_FACTOR_DEFAULT
) (
  axis_if.rx s_axis,
  axis_if.tx m_axis
);

  localparam int L    = INTERP_FACTOR;
  localparam int N    = $size(coeff);
  localparam int P    = N / L;
  localparam int PH_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(L - 1);

  if ($bits(s_axis.TDATA) != $bits(m_axis.TDATA)) begin : g_err_width
    $error("axis_fir_interp: s_axis and m_axis TDATA widths differ");
  end
  if (L < 2) begin : g_err_factor
    $error("axis_fir_interp: INTERP_FACTOR must be at least 2");
  end
  if ((N % L) != 0) begin : g_err_taps
    $error("axis_fir_interp: tap count must be a multiple of INTERP_FACTOR");
  end

  logic                 w_clk;
  logic                 w_rst_n;
  interp_state_t        r_state;
  interp_state_t        w_state_nxt;
  logic [PH_W-1:0]      r_phase;
  logic [PH_W-1:0]      w_phase_nxt;
  logic signed [63:0]   r_hist [P];
  logic                 r_tlast;
  logic                 w_s_tready;
  logic                 w_accept;
  logic signed [63:0]   w_mac;

  assign w_clk   = s_axis.ACLK;
  assign w_rst_n = s_axis.ARESETn;

  // Next-state, phase advance and input-ready decode.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_s_tready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_s_tready = 1'b1;
        if (s_axis.TVALID) begin
          w_state_nxt = EMIT;
          w_phase_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EMIT: begin
        if (m_axis.TREADY) begin
          if (r_phase != LAST_PH) begin
            w_phase_nxt = r_phase + PH_W'(1);
          end else begin
            // Last phase leaving: take the next sample in the same cycle if offered.
            w_s_tready  = 1'b1;
            w_phase_nxt = '0;
            if (s_axis.TVALID) begin
              w_state_nxt = EMIT;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end else begin
          w_state_nxt = EMIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  // Reset holds TREADY low even though the state register already reads IDLE.
  assign w_accept     = s_axis.TVALID && w_s_tready && w_rst_n;
  assign s_axis.TREADY = w_s_tready && w_rst_n;

  // State, phase counter, sample history and captured TLAST.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_tlast <= 1'b0;
      for (int j = 0; j < P; j++) begin
        r_hist[j] <= 64'sd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      if (w_accept) begin
        r_hist[0] <= s_axis.TDATA;
        for (int j = 1; j < P; j++) begin
          r_hist[j] <= r_hist[j-1];
        end
        r_tlast <= s_axis.TLAST;
      end
    end
  end

  fir_phase_mac #(
    .COEFF (coeff),
    .L     (L),
    .P     (P),
    .PH_W  (PH_W)
  ) u_mac (
    .i_phase (r_phase),
    .i_hist  (r_hist),
    .o_acc   (w_mac)
  );

  // Outputs depend only on registers, so they hold still under backpressure.
  assign m_axis.TVALID = (r_state == EMIT);
  assign m_axis.TDATA  = w_mac;
  assign m_axis.TLAST  = (r_state == EMIT) && r_tlast && (r_phase == LAST_PH);

endmodule

// File: tb/tb_axis_fir_interp.sv
module tb_axis_fir_interp;
  import fir_pkg::*;

  localparam int L_TB = 4;
  localparam int P_TB = 2;
  localparam fir_coeff_t COEFF_TWO = '{default: 16'sd2};

  logic clk;
  logic rst_n;

  axis_if #(.TDATA_W(64)) s0 (.ACLK(clk), .ARESETn(rst_n));
  axis_if #(.TDATA_W(64)) m0 (.ACLK(clk), .ARESETn(rst_n));
  axis_if #(.TDATA_W(64)) sw (.ACLK(clk), .ARESETn(rst_n));
  axis_if #(.TDATA_W(64)) mw (.ACLK(clk), .ARESETn(rst_n));

  axis_fir_interp dut (
    .s_axis (s0),
    .m_axis (m0)
  );

  axis_fir_interp #(.coeff(COEFF_TWO), .INTERP_FACTOR(4)) dut_w (
    .s_axis (sw),
    .m_axis (mw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint in_data [64];
  bit     in_last [64];
  longint xs [$];          // every sample accepted since reset, newest first
  int     h [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int     span;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    xs.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive in_data[0..n-1] with valid/ready probabilities pv/pr (percent) and
  // check every output handshake against the reference outputs.  Optionally
  // hold m TREADY low for stall_len cycles while output stall_at is presented.
  task automatic run_stream(input int n, input int pv, input int pr,
                            input int stall_at, input int stall_len, output int o_span);
    longint exp_d [$];
    bit     exp_l [$];
    int     exp_n, got, sent, budget, stall_left, first_c, last_c;
    bit     held, held_l, lat_pending, sv;
    logic [63:0] held_d;
    for (int i = 0; i < n; i++) begin
      xs.push_front(in_data[i]);
      for (int k = 0; k < L_TB; k++) begin
        longint acc = 0;
        for (int j = 0; j < P_TB; j++) begin
          if (j < xs.size()) acc += longint'(h[j*L_TB + k]) * xs[j];
        end
        exp_d.push_back(acc);
        exp_l.push_back(in_last[i] && (k == L_TB - 1));
      end
    end
    exp_n = n * L_TB; got = 0; sent = 0; budget = 0; stall_left = stall_len;
    first_c = -1; last_c = -1; held = 0; lat_pending = 0; held_d = '0; held_l = 0;
    while (got < exp_n && budget < 2000) begin
      @(negedge clk);
      sv = (sent < n) && ($urandom_range(99) < pv);
      s0.TVALID = sv;
      s0.TDATA  = sv ? in_data[sent] : 64'd0;
      s0.TLAST  = sv ? in_last[sent] : 1'b0;
      m0.TREADY = ($urandom_range(99) < pr);
      if (got == stall_at && stall_left > 0) m0.TREADY = 1'b0;
      #1;
      if (lat_pending) chk("first_out_latency", 64'(m0.TVALID), 64'd1);
      if (held) begin
        chk("hold_valid", 64'(m0.TVALID), 64'd1);
        chk("hold_data", m0.TDATA, held_d);
        chk("hold_last", 64'(m0.TLAST), 64'(held_l));
      end
      if (got == stall_at && stall_left > 0) begin
        chk("stall_data", m0.TDATA, exp_d[got]);
        chk("stall_s_ready", 64'(s0.TREADY), 64'd0);
        stall_left--;
      end
      lat_pending = sv && s0.TREADY && !m0.TVALID;
      if (m0.TVALID && m0.TREADY) begin
        chk($sformatf("out_data[%0d]", got), m0.TDATA, exp_d[got]);
        chk($sformatf("out_last[%0d]", got), 64'(m0.TLAST), 64'(exp_l[got]));
        if (first_c < 0) first_c = budget;
        last_c = budget;
        got++;
      end
      held   = m0.TVALID && !m0.TREADY;
      held_d = m0.TDATA;
      held_l = m0.TLAST;
      if (sv && s0.TREADY) sent++;
      budget++;
    end
    chk("stream_complete", 64'(got), 64'(exp_n));
    o_span = last_c - first_c + 1;
    @(negedge clk);
    s0.TVALID = 1'b0;
    s0.TLAST  = 1'b0;
    m0.TREADY = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    s0.TVALID = 1'b0; s0.TDATA = '0; s0.TLAST = 1'b0; m0.TREADY = 1'b1;
    sw.TVALID = 1'b0; sw.TDATA = '0; sw.TLAST = 1'b0; mw.TREADY = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(m0.TVALID), 64'd0);
    chk("rst_m_last", 64'(m0.TLAST), 64'd0);
    chk("rst_s_ready", 64'(s0.TREADY), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_s_ready", 64'(s0.TREADY), 64'd1);
    chk("idle_m_valid", 64'(m0.TVALID), 64'd0);

    // Impulse 1,0 -> 1..8
    in_data[0] = 1; in_data[1] = 0; in_last[0] = 0; in_last[1] = 0;
    run_stream(2, 100, 100, -1, 0, span);

    // Two-sample 10,20 -> 10,20,30,40,70,100,130,160
    in_data[0] = 10; in_data[1] = 20;
    run_stream(2, 100, 100, -1, 0, span);

    // Backpressure at phase 1 of an impulse
    do_reset();
    in_data[0] = 1; in_data[1] = 0;
    run_stream(2, 100, 100, 1, 3, span);

    // Continuous stream, TLAST on second input: eight outputs with no gap
    in_data[0] = longint'({$urandom, $urandom}); in_data[1] = longint'({$urandom, $urandom});
    in_last[0] = 0; in_last[1] = 1;
    run_stream(2, 100, 100, -1, 0, span);
    chk("continuous_span", 64'(span), 64'd8);

    // Reset mid-burst
    do_reset();
    @(negedge clk);
    s0.TVALID = 1'b1; s0.TDATA = 64'd1; s0.TLAST = 1'b0; m0.TREADY = 1'b1;
    @(negedge clk);
    s0.TVALID = 1'b0;
    @(negedge clk);
    #1;
    chk("midburst_phase1_data", m0.TDATA, 64'd2);
    #2;
    rst_n = 1'b0;
    xs.delete();
    #1;
    chk("midburst_rst_valid", 64'(m0.TVALID), 64'd0);
    chk("midburst_rst_s_ready", 64'(s0.TREADY), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_s_ready", 64'(s0.TREADY), 64'd1);
    @(negedge clk);
    #1;
    chk("post_rst_no_leftover", 64'(m0.TVALID), 64'd0);
    in_data[0] = 1; in_last[0] = 0;
    run_stream(1, 100, 100, -1, 0, span);

    // Randomized streams with random gaps and backpressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        in_data[i] = longint'({$urandom, $urandom});
        in_last[i] = ($urandom_range(3) == 0);
      end
      run_stream(16, 60, 55, -1, 0, span);
    end

    // Wrap: coeff all 2, input 0x7FFF... -> each output 0xFFFF...FFFE
    do_reset();
    @(negedge clk);
    sw.TVALID = 1'b1; sw.TDATA = 64'h7FFF_FFFF_FFFF_FFFF; mw.TREADY = 1'b1;
    #1;
    chk("wrap_s_ready", 64'(sw.TREADY), 64'd1);
    @(negedge clk);
    sw.TVALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("wrap_valid[%0d]", k), 64'(mw.TVALID), 64'd1);
      chk($sformatf("wrap_data[%0d]", k), mw.TDATA, 64'hFFFF_FFFF_FFFF_FFFE);
      @(negedge clk);
    end
    #1;
    chk("wrap_idle", 64'(mw.TVALID), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
